// File: rtl/cpu_nic.sv
// Memory-mapped NIC bridging the processor data port to the ring router local port; one RX and one TX packet buffer.
// Optional macro NIC_POLARITY_GATE_EN offers transmit only on even-polarity cycles.
module cpu_nic #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [0:DATA_W-1] d_in,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic [0:DATA_W-1] d_out,
  input  logic [0:DATA_W-1] net_di,
  input  logic              net_vi,
  output logic              net_ri,
  output logic [0:DATA_W-1] net_do,
  output logic              net_vo,
  input  logic              net_ro,
  input  logic              net_polarity
);

  localparam logic [ADDR_W-1:0] A_RX_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_RX_STAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TX_DATA = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TX_STAT = ADDR_W'(3);

  logic [0:DATA_W-1] rx_buf;
  logic              rx_full;
  logic [0:DATA_W-1] tx_buf;
  logic              tx_full;
  logic              gate;

`ifdef NIC_POLARITY_GATE_EN
  assign gate = !net_polarity;
`else
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign gate = 1'b1;
`endif

  logic load, store, rx_take, rx_pop, tx_drain, tx_accept;

  assign load      = nicEn && !nicWrEn;
  assign store     = nicEn && nicWrEn;
  assign net_ri    = !rx_full;
  assign rx_take   = net_vi && net_ri;
  assign rx_pop    = load && (addr == A_RX_DATA);
  assign net_do    = tx_buf;
  assign net_vo    = tx_full && gate;
  assign tx_drain  = net_vo && net_ro;
  // A drain on the same edge frees the slot, so a store then still lands.
  assign tx_accept = store && (addr == A_TX_DATA) && (!tx_full || tx_drain);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_buf  <= '0;
      rx_full <= 1'b0;
    end else if (rx_take) begin
      rx_buf  <= net_di;
      rx_full <= 1'b1;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (tx_accept) begin
      tx_buf  <= d_in;
      tx_full <= 1'b1;
    end else if (tx_drain) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (load) begin
      case (addr)
        A_RX_DATA: d_out <= rx_buf;
        A_RX_STAT: d_out <= {{(DATA_W-1){1'b0}}, rx_full};
        A_TX_STAT: d_out <= {{(DATA_W-1){1'b0}}, tx_full};
        default:   d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_nic.sv
// Randomized and directed bench for cpu_nic against a transaction-level model of the two buffers.
module tb_cpu_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = '0;
  logic [0:63] d_in = '0;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic [0:63] d_out;
  logic [0:63] net_di = '0;
  logic        net_vi = 1'b0;
  logic        net_ri;
  logic [0:63] net_do;
  logic        net_vo;
  logic        net_ro = 1'b0;
  logic        net_polarity = 1'b0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // model state: each buffer is a one-entry mailbox
  logic [63:0] m_rx_buf, m_tx_buf, m_dout;
  logic        m_rx_full, m_tx_full;

  cpu_nic #(.DATA_W(64), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .d_out(d_out), .net_di(net_di), .net_vi(net_vi), .net_ri(net_ri), .net_do(net_do),
    .net_vo(net_vo), .net_ro(net_ro), .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic offer_ok(input logic pol);
`ifdef NIC_POLARITY_GATE_EN
    return !pol;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_clear();
    m_rx_buf = '0; m_tx_buf = '0; m_dout = '0; m_rx_full = 1'b0; m_tx_full = 1'b0;
  endtask

  task automatic compare_all();
    check("net_ri", {63'b0, net_ri}, {63'b0, !m_rx_full});
    check("net_vo", {63'b0, net_vo}, {63'b0, m_tx_full && offer_ok(net_polarity)});
    check("net_do", net_do, m_tx_buf);
    check("d_out",  d_out,  m_dout);
  endtask

  // Inputs are already applied; advance one clock and update the model from them.
  task automatic cycle();
    logic        is_load, is_store, rx_take, drain, accept;
    logic [63:0] n_dout, n_rx_buf, n_tx_buf;
    logic        n_rx_full, n_tx_full;
    is_load  = nicEn && !nicWrEn;
    is_store = nicEn && nicWrEn;
    rx_take  = net_vi && !m_rx_full;
    drain    = m_tx_full && offer_ok(net_polarity) && net_ro;
    n_dout   = m_dout;
    if (is_load) begin
      if (addr == 2'd0)      n_dout = m_rx_buf;
      else if (addr == 2'd1) n_dout = 64'(m_rx_full);
      else if (addr == 2'd3) n_dout = 64'(m_tx_full);
      else                   n_dout = 64'd0;
    end
    n_rx_buf  = rx_take ? net_di : m_rx_buf;
    n_rx_full = rx_take ? 1'b1 : ((is_load && addr == 2'd0) ? 1'b0 : m_rx_full);
    accept    = is_store && addr == 2'd2 && (!m_tx_full || drain);
    n_tx_full = accept || (m_tx_full && !drain);
    n_tx_buf  = accept ? d_in : m_tx_buf;
    @(posedge clk);
    m_dout = n_dout; m_rx_buf = n_rx_buf; m_rx_full = n_rx_full;
    m_tx_buf = n_tx_buf; m_tx_full = n_tx_full;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; net_vi = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
  endtask

  task automatic do_store(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
  endtask

  initial begin
    model_clear();
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_net_ri", {63'b0, net_ri}, 64'd1);
    check("rst_net_vo", {63'b0, net_vo}, 64'd0);
    check("rst_d_out", d_out, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    compare_all();

    // 1. RX_STAT empty
    do_load(2'd1); cycle();
    check("rx_stat_empty", d_out, 64'd0);

    // 2. receive, poll, pop
    idle(); net_vi = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001; cycle();
    net_vi = 1'b0;
    check("rx_full_ri", {63'b0, net_ri}, 64'd0);
    do_load(2'd1); cycle();
    check("rx_stat_full", d_out, 64'd1);
    do_load(2'd0); cycle();
    check("rx_data", d_out, 64'hDEAD_BEEF_0000_0001);
    check("rx_popped_ri", {63'b0, net_ri}, 64'd1);

    // 3. transmit with backpressure, dropped second store, drain
    idle(); net_ro = 1'b0; net_polarity = 1'b0;
    do_store(2'd2, 64'h1234); cycle();
    check("tx_vo", {63'b0, net_vo}, 64'd1);
    check("tx_do", net_do, 64'h1234);
    do_load(2'd3); cycle();
    check("tx_stat", d_out, 64'd1);
    do_store(2'd2, 64'h5678); cycle();
    check("tx_drop", net_do, 64'h1234);
    idle(); net_ro = 1'b1; cycle();
    check("tx_drained", {63'b0, net_vo}, 64'd0);

    // 4. store lands on the same edge the buffer drains
    net_ro = 1'b0; do_store(2'd2, 64'h11); cycle();
    net_ro = 1'b1; do_store(2'd2, 64'hAA); cycle();
    idle(); net_ro = 1'b0;
    check("tx_refill_vo", {63'b0, net_vo}, 64'd1);
    check("tx_refill_do", net_do, 64'hAA);
    net_ro = 1'b1; cycle(); net_ro = 1'b0;

    // 5. RX held off while full; new capture only after the pop
    idle(); net_vi = 1'b1; net_di = 64'hA1; cycle();
    net_di = 64'hB2; cycle(); cycle();
    do_load(2'd0); cycle();
    check("rx_hold_old", d_out, 64'hA1);
    check("rx_after_pop_ri", {63'b0, net_ri}, 64'd1);
    nicEn = 1'b0; cycle();
    net_vi = 1'b0; do_load(2'd0); cycle();
    check("rx_new", d_out, 64'hB2);
    idle();

`ifdef NIC_POLARITY_GATE_EN
    // 6. drain only on an even-polarity edge
    net_ro = 1'b0; do_store(2'd2, 64'h77); cycle();
    idle(); net_ro = 1'b1; net_polarity = 1'b1; cycle();
    check("pol_odd_hold", {63'b0, m_tx_full}, 64'd1);
    net_polarity = 1'b0; cycle();
    check("pol_even_drain", {63'b0, net_vo}, 64'd0);
    net_ro = 1'b0;
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      nicEn        = ($urandom_range(0, 1) == 1);
      nicWrEn      = ($urandom_range(0, 1) == 1);
      addr         = 2'($urandom_range(0, 3));
      d_in         = {$urandom, $urandom};
      net_vi       = ($urandom_range(0, 2) == 0);
      net_di       = {$urandom, $urandom};
      net_ro       = ($urandom_range(0, 2) != 0);
      net_polarity = ($urandom_range(0, 1) == 1);
      cycle();
    end

    // mid-operation asynchronous reset
    idle(); net_ro = 1'b0; net_polarity = 1'b0;
    do_store(2'd2, 64'h99); cycle();
    idle(); net_vi = 1'b1; net_di = 64'h55; cycle();
    do_load(2'd1); cycle();
    idle();
    #2 reset = 1'b0;
    #1;
    model_clear();
    check("arst_ri", {63'b0, net_ri}, 64'd1);
    check("arst_vo", {63'b0, net_vo}, 64'd0);
    check("arst_d_out", d_out, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
